// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the unified-memory arbiter.
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_C = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int TIMEOUT_CNT_W   = $clog2(DEFAULT_TIMEOUT + 1);

    // A disabled timeout still needs a one-bit counter to keep widths legal.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester, memory and status signals of the memory arbiter.
// Revision    : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_done;
    logic              c_err;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic              d_err;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output c_gnt, c_done, c_err, c_rdata,
        output d_gnt, d_done, d_err, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  c_gnt, c_done, c_err, c_rdata,
        input  d_gnt, d_done, d_err, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_rr
// Description : Two-way round-robin picker; the pointer lives in the parent.
// Revision    : 1.0
// ============================================================================
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       c_req,
    input  logic       d_req,
    input  requester_t last,
    output requester_t winner
);

    always_comb begin
        winner = REQ_C;
        if (c_req && d_req) begin
            if (last == REQ_C) begin
                winner = REQ_D;
            end
        end else if (d_req) begin
            winner = REQ_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Core/debug arbiter for the unified memory with ready/timeout.
// Revision    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int                CNT_W        = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    requester_t        owner_q, owner_d;
    requester_t        last_q,  last_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;
    requester_t        winner;

    mem_arb_rr u_rr (
        .c_req  (bus.c_req),
        .d_req  (bus.d_req),
        .last   (last_q),
        .winner (winner)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.c_req || bus.d_req) begin
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = ACCESS;
                    if (winner == REQ_D) begin
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                    end else begin
                        we_d    = bus.c_we;
                        addr_d  = bus.c_addr;
                        wdata_d = bus.c_wdata;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ready is checked first so a late ready still beats the timeout.
                if (bus.mem_ready) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = owner_q;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= REQ_C;
            last_q  <= REQ_D;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    logic in_access, in_resp, own_c, own_d;
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign own_c     = (owner_q == REQ_C);
    assign own_d     = (owner_q == REQ_D);

    assign bus.c_gnt   = in_access && own_c;
    assign bus.c_done  = in_resp && own_c;
    assign bus.c_err   = in_resp && own_c && err_q;
    assign bus.c_rdata = (in_resp && own_c) ? rdata_q : '0;

    assign bus.d_gnt   = in_access && own_d;
    assign bus.d_done  = in_resp && own_d;
    assign bus.d_err   = in_resp && own_d && err_q;
    assign bus.d_rdata = (in_resp && own_d) ? rdata_q : '0;

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && we_q;
    assign bus.mem_addr  = in_access ? addr_q  : '0;
    assign bus.mem_wdata = in_access ? wdata_q : '0;
    assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the multicycle core's single unified instruction/data memory between two requesters: the core (port C) and a debug/program-loader port (port D).
- Sequences each access as one memory transaction with a variable-latency ready handshake and a timeout.
- Returns a registered response to the owning requester.
- Sits between the core datapath's memory address/write-data path and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, max ACCESS cycles waiting for mem_ready before error; 0 disables timeout

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
c_req  input  1  core request; hold with fields stable until c_done
c_we  input  1  core write enable (1=write, 0=read)
c_addr  input  ADDR_W  core address
c_wdata  input  DATA_W  core write data
c_gnt  output  1  high during ACCESS cycles owned by core
c_done  output  1  one-cycle completion pulse to core
c_err  output  1  valid with c_done; 1=timeout
c_rdata  output  DATA_W  read data, valid with c_done
d_req, d_we, d_addr, d_wdata  inputs  1/1/ADDR_W/DATA_W  debug port, same rules as core
d_gnt, d_done, d_err, d_rdata  outputs  1/1/1/DATA_W  debug port, same rules as core
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1
mem_ready  input  1  memory completes access this cycle
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, all outputs 0, rr pointer last=D (core wins the first tie), timeout counter=0.
- Reset mid-access: the access is aborted at that edge. No done pulse is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select the owner, latch its we/addr/wdata into internal registers, go to ACCESS.
  - Tie-break: round-robin; grant the requester not served last.
  - Single request: grant it regardless of the pointer.
- ACCESS:
  - mem_en=1. mem_we/addr/wdata are driven from the latched registers.
  - Owner's gnt=1. Counter increments every ACCESS cycle.
  - If mem_ready=1: latch mem_rdata (reads) or 0 (writes), err=0, go to RESP.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: latch rdata=0, err=1, go to RESP.
- RESP:
  - Owner's done=1 for exactly one cycle. rdata/err are stable.
  - rr pointer is updated to the owner. Counter is cleared. Go to IDLE.
- Latency: req seen in cycle 0 -> mem_en in cycle 1 -> zero-wait ready in cycle 1 -> done in cycle 2 -> IDLE in cycle 3. Minimum 3 cycles per access; each wait state adds 1.
- Requests arriving during ACCESS/RESP are held pending and arbitrated on the next IDLE.
- A requester holding req through done is re-granted only if it wins round-robin. Back-to-back requests from both ports therefore alternate C, D, C, D.
- req deasserted mid-access is ignored: the access completes and done is still pulsed.
- Changes to the owner's input fields after the grant have no effect (fields are latched).
- Non-owner outputs: gnt=0, done=0, err=0, rdata=0 at all times.
- mem_ready while state != ACCESS is ignored.
- Timeout reached on the same cycle mem_ready=1: ready wins, err=0.
- All outputs are registered or decoded from state plus latched registers. There is no combinational path from req to mem_*.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ACCESS, RESP}
  - requester_t enum {REQ_C=0, REQ_D=1}
  - timeout counter width constant, derived as $clog2(TIMEOUT+1)
- One sub-module, mem_arb_rr: 2-way round-robin picker.
  - Inputs: c_req, d_req, last.
  - Output: winner.
  - Combinational, with the pointer register kept in the parent.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with c_req=d_req=1 -> all outputs 0, busy=0. Release -> core granted first; mem_en rises 1 cycle after release.
2. Zero-wait read: c_req=1, c_addr=0x10, c_we=0, mem_ready=1 with mem_rdata=0xDEADBEEF during ACCESS -> c_done 2 cycles after req, c_rdata=0xDEADBEEF, c_err=0, d_* outputs stay 0.
3. Contention: c_req and d_req held high for 4 accesses (d_addr=0x20, d_we=1, d_wdata=0x55), mem_ready=1 -> grant order C, D, C, D; mem_we=1 only during D accesses, with mem_addr=0x20 and mem_wdata=0x55.
4. Wait states: d_req read, mem_ready low for 3 ACCESS cycles then high -> mem_en high exactly 4 cycles; d_done 5 cycles after req.
5. Timeout: TIMEOUT=16, mem_ready held 0 -> mem_en high 16 cycles, then c_done=1 with c_err=1 and c_rdata=0. Repeat with mem_ready=1 on cycle 16 -> c_err=0.
6. Abort and stability: assert reset=0 in the 2nd ACCESS cycle -> no done pulse and mem_en=0 next cycle. Separately, change c_addr and deassert c_req mid-ACCESS -> mem_addr unchanged and c_done still pulses.
